// File: rtl/mmu_arbiter_pkg.sv
// Shared definitions for the MMU bus arbiter: FSM encoding and request slots.
// Slot index order doubles as issue priority (lowest index wins).
package mmu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NREQ = 3;

    localparam logic [1:0] WR = 2'd0;
    localparam logic [1:0] DR = 2'd1;
    localparam logic [1:0] IR = 2'd2;

    function automatic logic [1:0] first_set(input logic [NREQ-1:0] f);
        if (f[WR]) begin
            return WR;
        end else if (f[DR]) begin
            return DR;
        end
        return IR;
    endfunction

endpackage

// File: rtl/mmu_arbiter_watchdog.sv
// Memory-ack watchdog: counts cycles a bus request waits without ack.
// Latency: o_expire is combinational on the TIMEOUT_CYCLES-th unacked sampled cycle.
// Backpressure: none; restarts on every newly issued request.
module mmu_arbiter_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_active && !i_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_start || o_expire) begin
            r_cnt <= '0;
        end else if (i_active && !i_ack) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mmu_arbiter.sv
// Arbitrates instruction fetch, data read and data write onto one memory bus (write > data read > fetch).
// Latency: bus request the cycle after capture; RVALID the cycle after MEM_ACK. Backpressure: MEM_WAIT stalls the core.
// Optional ack watchdog enabled by defining MMU_ARBITER_TIMEOUT_EN.
module mmu_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        BUS_ERR
);

    import mmu_arbiter_pkg::*;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mmu_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_pend, w_in_flags, w_rem, w_sel_flags;
    logic [1:0]  r_cur, w_sel;
    logic [31:0] r_wr_addr, r_wr_data, r_dr_addr, r_ir_addr;
    logic [31:0] w_sel_addr, w_sel_wdata, w_rdata;
    logic        w_capture, w_done, w_chain, w_expire;

    logic        r_mem_req, r_mem_we;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic        r_inst_rvalid, r_data_rvalid;
    logic [31:0] r_inst_roaddr, r_inst_rdata, r_data_roaddr, r_data_rdata;

    always_comb begin
        w_in_flags  = {INST_RDEN, DATA_RDEN, DATA_WREN};
        w_rem       = r_pend;
        w_rem[r_cur] = 1'b0;
        w_capture   = (r_state == ST_IDLE) && (|w_in_flags);
        w_done      = (r_state == ST_ISSUE) && r_mem_req && (MEM_ACK || w_expire);
        w_chain     = w_done && (|w_rem);
        w_sel_flags = (r_state == ST_IDLE) ? w_in_flags : w_rem;
        w_sel       = first_set(w_sel_flags);
        // Timed-out transactions complete with zero data.
        w_rdata     = MEM_ACK ? MEM_RDATA : 32'd0;
        w_sel_addr  = 32'd0;
        w_sel_wdata = 32'd0;
        if (r_state == ST_IDLE) begin
            case (w_sel)
                WR: begin
                    w_sel_addr  = DATA_WADDR;
                    w_sel_wdata = DATA_WDATA;
                end
                DR:      w_sel_addr = DATA_RIADDR;
                default: w_sel_addr = INST_RIADDR;
            endcase
        end else begin
            case (w_sel)
                WR: begin
                    w_sel_addr  = r_wr_addr;
                    w_sel_wdata = r_wr_data;
                end
                DR:      w_sel_addr = r_dr_addr;
                default: w_sel_addr = r_ir_addr;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_capture) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_done && !w_chain) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pend        <= '0;
            r_cur         <= WR;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_dr_addr     <= '0;
            r_ir_addr     <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_inst_rvalid <= 1'b0;
            r_inst_roaddr <= '0;
            r_inst_rdata  <= '0;
            r_data_rvalid <= 1'b0;
            r_data_roaddr <= '0;
            r_data_rdata  <= '0;
        end else begin
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;

            if (w_capture) begin
                r_pend    <= w_in_flags;
                r_wr_addr <= DATA_WADDR;
                r_wr_data <= DATA_WDATA;
                r_dr_addr <= DATA_RIADDR;
                r_ir_addr <= INST_RIADDR;
            end else if (w_done) begin
                r_pend <= w_rem;
            end

            // Chaining straight from the ack edge keeps MEM_REQ high with no bubble.
            if (w_capture || w_chain) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= (w_sel == WR);
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_cur       <= w_sel;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end

            if (w_done && (r_cur == DR)) begin
                r_data_rvalid <= 1'b1;
                r_data_roaddr <= r_dr_addr;
                r_data_rdata  <= w_rdata;
            end
            if (w_done && (r_cur == IR)) begin
                r_inst_rvalid <= 1'b1;
                r_inst_roaddr <= r_ir_addr;
                r_inst_rdata  <= w_rdata;
            end
        end
    end

`ifdef MMU_ARBITER_TIMEOUT_EN
    logic r_bus_err;

    mmu_arbiter_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_start  (w_capture || w_chain),
        .i_active (r_mem_req),
        .i_ack    (MEM_ACK),
        .o_expire (w_expire)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_expire && (r_state == ST_ISSUE);
        end
    end

    assign BUS_ERR = r_bus_err;
`else
    assign w_expire = 1'b0;
    assign BUS_ERR  = 1'b0;
`endif

    assign MEM_WAIT    = (r_state != ST_IDLE);
    assign MEM_REQ     = r_mem_req;
    assign MEM_WE      = r_mem_we;
    assign MEM_ADDR    = r_mem_addr;
    assign MEM_WDATA   = r_mem_wdata;
    assign INST_RVALID = r_inst_rvalid;
    assign INST_ROADDR = r_inst_roaddr;
    assign INST_RDATA  = r_inst_rdata;
    assign DATA_RVALID = r_data_rvalid;
    assign DATA_ROADDR = r_data_roaddr;
    assign DATA_RDATA  = r_data_rdata;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter: single fetch, priority chaining, input isolation under stall, reset abort, timeout.
module tb_mmu_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INST_RDEN;
    logic [31:0] INST_RIADDR;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        DATA_RDEN;
    logic [31:0] DATA_RIADDR;
    logic [31:0] DATA_ROADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [31:0] DATA_WDATA;
    logic        MEM_WAIT;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic        BUS_ERR;

    int errors = 0;
    int checks = 0;

    mmu_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .INST_RDEN   (INST_RDEN),
        .INST_RIADDR (INST_RIADDR),
        .INST_ROADDR (INST_ROADDR),
        .INST_RVALID (INST_RVALID),
        .INST_RDATA  (INST_RDATA),
        .DATA_RDEN   (DATA_RDEN),
        .DATA_RIADDR (DATA_RIADDR),
        .DATA_ROADDR (DATA_ROADDR),
        .DATA_RVALID (DATA_RVALID),
        .DATA_RDATA  (DATA_RDATA),
        .DATA_WREN   (DATA_WREN),
        .DATA_WADDR  (DATA_WADDR),
        .DATA_WDATA  (DATA_WDATA),
        .MEM_WAIT    (MEM_WAIT),
        .MEM_REQ     (MEM_REQ),
        .MEM_WE      (MEM_WE),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_ACK     (MEM_ACK),
        .MEM_RDATA   (MEM_RDATA),
        .BUS_ERR     (BUS_ERR)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        INST_RDEN   = 1'b0;
        INST_RIADDR = 32'd0;
        DATA_RDEN   = 1'b0;
        DATA_RIADDR = 32'd0;
        DATA_WREN   = 1'b0;
        DATA_WADDR  = 32'd0;
        DATA_WDATA  = 32'd0;
    endtask

    initial begin
        RST       = 1'b0;
        MEM_ACK   = 1'b0;
        MEM_RDATA = 32'd0;
        clear_inputs();
        step();
        step();
        chk("rst_wait", {31'd0, MEM_WAIT}, 32'd0);
        chk("rst_req", {31'd0, MEM_REQ}, 32'd0);
        chk("rst_berr", {31'd0, BUS_ERR}, 32'd0);
        chk("rst_irv", {31'd0, INST_RVALID}, 32'd0);
        RST = 1'b1;
        step();

        // Single fetch, ack sampled two edges after capture.
        INST_RDEN   = 1'b1;
        INST_RIADDR = 32'h2000_0000;
        step();
        clear_inputs();
        chk("f_req", {31'd0, MEM_REQ}, 32'd1);
        chk("f_we", {31'd0, MEM_WE}, 32'd0);
        chk("f_addr", MEM_ADDR, 32'h2000_0000);
        chk("f_wait", {31'd0, MEM_WAIT}, 32'd1);
        step();
        chk("f_norv", {31'd0, INST_RVALID}, 32'd0);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h0000_0013;
        step();
        MEM_ACK = 1'b0;
        chk("f_rv", {31'd0, INST_RVALID}, 32'd1);
        chk("f_rdata", INST_RDATA, 32'h0000_0013);
        chk("f_roaddr", INST_ROADDR, 32'h2000_0000);
        chk("f_req_drop", {31'd0, MEM_REQ}, 32'd0);
        chk("f_done_wait", {31'd0, MEM_WAIT}, 32'd1);
        step();
        chk("f_rv_pulse", {31'd0, INST_RVALID}, 32'd0);
        chk("f_idle", {31'd0, MEM_WAIT}, 32'd0);

        // Write + data read + fetch together: chained in priority order with no bubble.
        DATA_WREN   = 1'b1;
        DATA_WADDR  = 32'h1000_0004;
        DATA_WDATA  = 32'hDEAD_BEEF;
        DATA_RDEN   = 1'b1;
        DATA_RIADDR = 32'h1000_0008;
        INST_RDEN   = 1'b1;
        INST_RIADDR = 32'h2000_0004;
        step();
        clear_inputs();
        chk("p_wr_we", {31'd0, MEM_WE}, 32'd1);
        chk("p_wr_addr", MEM_ADDR, 32'h1000_0004);
        chk("p_wr_data", MEM_WDATA, 32'hDEAD_BEEF);
        MEM_ACK = 1'b1;
        step();
        chk("p_dr_req", {31'd0, MEM_REQ}, 32'd1);
        chk("p_dr_we", {31'd0, MEM_WE}, 32'd0);
        chk("p_dr_addr", MEM_ADDR, 32'h1000_0008);
        chk("p_wr_norv", {30'd0, DATA_RVALID, INST_RVALID}, 32'd0);
        MEM_RDATA = 32'hCAFE_0001;
        step();
        MEM_ACK = 1'b0;
        chk("p_dr_rv", {31'd0, DATA_RVALID}, 32'd1);
        chk("p_dr_rdata", DATA_RDATA, 32'hCAFE_0001);
        chk("p_dr_roaddr", DATA_ROADDR, 32'h1000_0008);
        chk("p_ir_req", {31'd0, MEM_REQ}, 32'd1);
        chk("p_ir_addr", MEM_ADDR, 32'h2000_0004);
        chk("p_ir_norv", {31'd0, INST_RVALID}, 32'd0);
        step();
        chk("p_dr_pulse", {31'd0, DATA_RVALID}, 32'd0);
        chk("p_ir_hold", MEM_ADDR, 32'h2000_0004);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h0010_0073;
        step();
        MEM_ACK = 1'b0;
        chk("p_ir_rv", {31'd0, INST_RVALID}, 32'd1);
        chk("p_ir_rdata", INST_RDATA, 32'h0010_0073);
        chk("p_ir_roaddr", INST_ROADDR, 32'h2000_0004);
        chk("p_end_req", {31'd0, MEM_REQ}, 32'd0);
        chk("p_end_drv", {31'd0, DATA_RVALID}, 32'd0);
        step();
        chk("p_ir_pulse", {31'd0, INST_RVALID}, 32'd0);
        chk("p_idle", {31'd0, MEM_WAIT}, 32'd0);

        // Inputs changing while stalled must not be captured.
        DATA_RDEN   = 1'b1;
        DATA_RIADDR = 32'h1000_0010;
        step();
        chk("s_addr0", MEM_ADDR, 32'h1000_0010);
        DATA_WREN   = 1'b1;
        DATA_WADDR  = 32'h1000_0020;
        DATA_WDATA  = 32'h1234_5678;
        INST_RDEN   = 1'b1;
        INST_RIADDR = 32'h2000_0040;
        DATA_RIADDR = 32'h1000_0099;
        step();
        chk("s_addr1", MEM_ADDR, 32'h1000_0010);
        chk("s_we1", {31'd0, MEM_WE}, 32'd0);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h0000_0055;
        step();
        MEM_ACK = 1'b0;
        clear_inputs();
        chk("s_rv", {31'd0, DATA_RVALID}, 32'd1);
        chk("s_roaddr", DATA_ROADDR, 32'h1000_0010);
        chk("s_req_drop", {31'd0, MEM_REQ}, 32'd0);
        step();
        chk("s_idle", {31'd0, MEM_WAIT}, 32'd0);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'hFFFF_FFFF;
        step();
        MEM_ACK = 1'b0;
        chk("s_stray_ack_rv", {30'd0, DATA_RVALID, INST_RVALID}, 32'd0);
        chk("s_rdata_hold", DATA_RDATA, 32'h0000_0055);
        chk("s_no_capture", {31'd0, MEM_REQ}, 32'd0);

        // Reset mid-transaction, then a late ack for the aborted request.
        INST_RDEN   = 1'b1;
        INST_RIADDR = 32'h2000_0100;
        step();
        clear_inputs();
        chk("r_req", {31'd0, MEM_REQ}, 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("r_req_async", {31'd0, MEM_REQ}, 32'd0);
        chk("r_wait_async", {31'd0, MEM_WAIT}, 32'd0);
        chk("r_addr_async", MEM_ADDR, 32'd0);
        step();
        RST = 1'b1;
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h0000_0077;
        step();
        MEM_ACK = 1'b0;
        chk("r_late_rv", {31'd0, INST_RVALID}, 32'd0);
        chk("r_late_rdata", INST_RDATA, 32'd0);
        chk("r_late_wait", {31'd0, MEM_WAIT}, 32'd0);

        // Data read left unacked.
        DATA_RDEN   = 1'b1;
        DATA_RIADDR = 32'h3000_0000;
        step();
        clear_inputs();
        chk("t_addr", MEM_ADDR, 32'h3000_0000);
`ifdef MMU_ARBITER_TIMEOUT_EN
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t_berr_early", {31'd0, BUS_ERR}, 32'd0);
            chk("t_req_held", {31'd0, MEM_REQ}, 32'd1);
        end
        step();
        chk("t_berr", {31'd0, BUS_ERR}, 32'd1);
        chk("t_drv", {31'd0, DATA_RVALID}, 32'd1);
        chk("t_rdata0", DATA_RDATA, 32'd0);
        chk("t_roaddr", DATA_ROADDR, 32'h3000_0000);
        chk("t_req_drop", {31'd0, MEM_REQ}, 32'd0);
        step();
        chk("t_berr_pulse", {31'd0, BUS_ERR}, 32'd0);
        chk("t_drv_pulse", {31'd0, DATA_RVALID}, 32'd0);
        chk("t_idle", {31'd0, MEM_WAIT}, 32'd0);
`else
        for (int i = 1; i <= 8; i++) begin
            step();
        end
        chk("t_req_held", {31'd0, MEM_REQ}, 32'd1);
        chk("t_no_berr", {31'd0, BUS_ERR}, 32'd0);
        chk("t_no_rv", {31'd0, DATA_RVALID}, 32'd0);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'hA5A5_0001;
        step();
        MEM_ACK = 1'b0;
        chk("t_late_rv", {31'd0, DATA_RVALID}, 32'd1);
        chk("t_late_rdata", DATA_RDATA, 32'hA5A5_0001);
        step();
        chk("t_idle", {31'd0, MEM_WAIT}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
